// File: rtl/memory_if.sv
// memory_if: valid/ready access port for the word memory.
// master drives the request, slave returns ready and read data.
interface memory_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  valid;
  logic                  ready;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output valid,
    output wr_rd,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wr_rd,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );
endinterface

// File: rtl/memory.sv
// memory: single-port word store behind a valid/ready port.
// MEMORY_WAIT_STATE_EN inserts an IDLE/ACK wait state per access.
module memory #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     res,
  memory_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             rdy_q;
  logic [WIDTH-1:0] rdata_q;
  logic             xfer;
  logic             in_range;

  assign in_range  = {1'b0, bus.addr} < LIMIT;
  assign xfer      = res & bus.valid & rdy_q;
  assign bus.ready = rdy_q;
  assign bus.rdata = rdata_q;

`ifdef MEMORY_WAIT_STATE_EN
  typedef enum logic {IDLE, ACK} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.valid) begin
            state <= ACK;
            rdy_q <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          rdy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!res) rdy_q <= 1'b0;
    else      rdy_q <= 1'b1;
  end
`endif

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (xfer && bus.wr_rd && in_range)
      mem[bus.addr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      rdata_q <= '0;
    end else if (xfer && !bus.wr_rd) begin
      rdata_q <= in_range ? mem[bus.addr] : '0;
    end
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: vector table, directed sequences and random traffic
// against an array model of the memory.
module tb_memory;
`ifdef MEMORY_WAIT_STATE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic res = 1'b0;

  memory_if #(.WIDTH(8), .ADDR_WIDTH(5)) bus ();

  memory #(.WIDTH(8), .DEPTH(32)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [32];
  logic [7:0] exp_rd;

  typedef struct {
    bit         wr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input bit wr,
                      input logic [4:0] a,
                      input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.wr_rd = wr;
    bus.addr  = a;
    bus.wdata = d;
    while (bus.ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    if (bus.ready === 1'b1) begin
      @(posedge clk);
      #1;
      if (wr) mem_m[a] = d;
      else    exp_rd = mem_m[a];
    end
    bus.valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0;
    bus.valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", bus.ready, 0);
      check("rst_rdata", bus.rdata, 0);
    end
    res = 1'b1;
    exp_rd = 8'h00;
    @(negedge clk);
    check("ready_after_rst", bus.ready, (LAT == 0) ? 1 : 0);
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.wr_rd = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    exp_rd    = 8'h00;

    vecs[0]  = '{1'b1, 5'd15, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 5'd15, 8'h00, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      vecs[2+i] = '{1'b1, 5'(3+i), 8'(8'h11*(i+1)), 8'h00};
      vecs[7+i] = '{1'b0, 5'(3+i), 8'h00, 8'(8'h11*(i+1))};
    end

    do_reset();

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].wr, vecs[i].a, vecs[i].d);
      if (!vecs[i].wr)
        check($sformatf("vec%0d", i), bus.rdata, vecs[i].exp);
    end

    for (int i = 0; i < 32; i++)
      xfer(1'b1, 5'(i), 8'(i) ^ 8'hFF);
    for (int i = 0; i < 32; i++) begin
      xfer(1'b0, 5'(i), 8'h00);
      check($sformatf("sweep%0d", i), bus.rdata, 8'(i) ^ 8'hFF);
    end
    for (int i = 0; i < 32; i++)
      check($sformatf("dump%0d", i), dut.mem[i], 8'(i) ^ 8'hFF);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      dut.mem[3+i] = 8'(8'h10*(i+1));
      mem_m[3+i]   = 8'(8'h10*(i+1));
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 5'(3+i), 8'h00);
      check($sformatf("bd%0d", i), bus.rdata, 8'(8'h10*(i+1)));
      check("ready_post", bus.ready, (LAT == 0) ? 1 : 0);
    end
    xfer(1'b0, 5'd20, 8'h00);
    check("survive_rst", bus.rdata, 8'd20 ^ 8'hFF);

    for (int i = 0; i < 32; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      xfer(1'b1, 5'(i), d);
      xfer(1'b0, 5'(i), 8'h00);
      check($sformatf("consec%0d", i), bus.rdata, d);
    end

    for (int k = 0; k < 300; k++) begin
      int op;
      op = int'($urandom_range(2));
      if (op == 2) begin
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wr_rd = 1'($urandom);
        bus.addr  = 5'($urandom_range(31));
        bus.wdata = 8'($urandom);
        @(posedge clk);
        #1;
        check("idle_hold", bus.rdata, exp_rd);
      end else begin
        logic [4:0] a;
        a = 5'($urandom_range(31));
        xfer(op == 1, a, 8'($urandom));
        if (op == 0)
          check("rand_rd", bus.rdata, mem_m[a]);
      end
    end

    xfer(1'b1, 5'd9, 8'h3C);
    xfer(1'b0, 5'd9, 8'h00);
    check("pre_rst_rd", bus.rdata, 8'h3C);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.wr_rd = 1'b1;
    bus.addr  = 5'd9;
    bus.wdata = 8'h77;
    res       = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_ready", bus.ready, 0);
      check("mid_rst_rdata", bus.rdata, 0);
    end
    bus.valid = 1'b0;
    res = 1'b1;
    @(negedge clk);
    xfer(1'b0, 5'd9, 8'h00);
    check("abort_rd", bus.rdata, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
